// File: rtl/uart_rx.sv
// UART receiver: oversampled, 2-flop synchronised serial input, 8N1-style
// framing (start, DATA_WIDTH data bits LSB first, one stop bit, no parity).
// Delivers each good word with a one-cycle rx_done strobe and flags bad stop
// bits with a one-cycle frame_err strobe.
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rx,
  input  logic                  baud_tick,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rx_done,
  output logic                  frame_err,
  output logic                  rx_busy
);

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t                  state;
  logic                    rx_meta;
  logic                    rx_s;
  logic [TW-1:0]           tick_cnt;
  logic [BW-1:0]           bit_cnt;
  logic [DATA_WIDTH-1:0]   shreg;

  // Two-flop synchroniser; resets to the idle (high) line level so a reset
  // never looks like a start bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Receive FSM with registered outputs; strobes default low every cycle and
  // rx_busy is updated together with every state change so it tracks state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      data_out  <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      rx_busy   <= 1'b0;
    end else begin
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state    <= START;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            rx_busy  <= 1'b1;
          end
        end

        START: begin
          if (baud_tick) begin
            if (tick_cnt == HALF_LAST) begin
              tick_cnt <= '0;
              if (!rx_s) begin
                state <= DATA;
              end else begin
                state   <= IDLE;
                rx_busy <= 1'b0;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        DATA: begin
          if (baud_tick) begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              shreg    <= {rx_s, shreg[DATA_WIDTH-1:1]};
              if (bit_cnt == BIT_LAST) begin
                bit_cnt <= '0;
                state   <= STOP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        STOP: begin
          if (baud_tick) begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              state    <= IDLE;
              rx_busy  <= 1'b0;
              if (rx_s) begin
                data_out <= shreg;
                rx_done  <= 1'b1;
              end else begin
                frame_err <= 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        default: begin
          state    <= IDLE;
          tick_cnt <= '0;
          bit_cnt  <= '0;
          rx_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a behavioural transmitter drives rx, expected
// words are queued as frames are sent and compared when rx_done/frame_err fire.
module tb_uart_rx;

  localparam int DW = 8;
  localparam int OS = 16;

  typedef struct {
    logic          isErr;
    logic [DW-1:0] data;
  } expect_t;

  logic          clock;
  logic          reset;
  logic          rx;
  logic          baud_tick;
  logic [DW-1:0] data_out;
  logic          rx_done;
  logic          frame_err;
  logic          rx_busy;

  int      checkCount = 0;
  int      errorCount = 0;
  int      tickDiv    = 4;
  int      divCnt     = 0;
  int      cycleCount = 0;
  int      stopCycle  = 0;
  logic [DW-1:0] lastGood = '0;
  expect_t sbQueue[$];

  uart_rx #(.DATA_WIDTH(DW), .OVERSAMPLE(OS)) dut (
    .clock     (clock),
    .reset     (reset),
    .rx        (rx),
    .baud_tick (baud_tick),
    .data_out  (data_out),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  // Free-running system clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Cycle counter used to time rx_done against the start of the stop bit
  always @(posedge clock) cycleCount <= cycleCount + 1;

  // Baud tick generator, updated on the falling edge so it is stable at posedge
  initial begin
    baud_tick = 1'b0;
    forever begin
      @(negedge clock);
      divCnt    = (divCnt + 1 >= tickDiv) ? 0 : divCnt + 1;
      baud_tick = (divCnt == 0);
    end
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Wait for n baud ticks as seen by the DUT on a rising edge
  task automatic waitTicks(input int n);
    repeat (n) begin
      @(posedge clock);
      while (!baud_tick) @(posedge clock);
    end
  endtask

  task automatic sendBit(input logic b);
    #1 rx = b;
    waitTicks(OS);
  endtask

  // Drive one frame and, unless told otherwise, queue what the DUT should report
  task automatic applyStimulus(input logic [DW-1:0] data, input logic stopVal);
    expect_t e;
    e.isErr = ~stopVal;
    e.data  = data;
    sbQueue.push_back(e);
    sendBit(1'b0);
    for (int i = 0; i < DW; i++) sendBit(data[i]);
    #1 rx = stopVal;
    stopCycle = cycleCount;
    waitTicks(OS);
    #1 rx = 1'b1;
  endtask

  // Output monitor: sampled on the falling edge, away from the active edge
  always @(negedge clock) begin
    if (!reset && (rx_done || frame_err)) begin
      expect_t e;
      checkOutput("strobe_exclusive", {31'd0, rx_done & frame_err}, 32'd0);
      checkOutput("stop_latency", {31'd0, (cycleCount - stopCycle) <= OS * tickDiv}, 32'd1);
      if (sbQueue.size() == 0) begin
        checkOutput("unexpected_strobe", {30'd0, rx_done, frame_err}, 32'd0);
      end else begin
        e = sbQueue.pop_front();
        checkOutput("strobe_kind", {31'd0, frame_err}, {31'd0, e.isErr});
        if (e.isErr) begin
          checkOutput("data_held_on_err", {24'd0, data_out}, {24'd0, lastGood});
        end else begin
          checkOutput("data_out", {24'd0, data_out}, {24'd0, e.data});
          lastGood = e.data;
        end
      end
    end
  end

  initial begin
    int waitCnt;
    rx    = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checkOutput("reset_data_out", {24'd0, data_out}, 32'd0);
    checkOutput("reset_rx_done", {31'd0, rx_done}, 32'd0);
    checkOutput("reset_frame_err", {31'd0, frame_err}, 32'd0);
    checkOutput("reset_rx_busy", {31'd0, rx_busy}, 32'd0);
    waitTicks(4);

    // Single framed word
    applyStimulus(8'h55, 1'b1);
    waitTicks(OS);
    checkOutput("idle_after_55", {31'd0, rx_busy}, 32'd0);

    // Back-to-back words without an idle gap
    applyStimulus(8'hA3, 1'b1);
    applyStimulus(8'h0F, 1'b1);
    waitTicks(OS);

    // Short glitch: 12 clocks low is under half a bit, so nothing is reported
    @(posedge clock);
    #1 rx = 1'b0;
    repeat (12) @(posedge clock);
    #1 rx = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("glitch_busy_seen", {31'd0, rx_busy}, 32'd1);
    waitTicks(OS);
    @(negedge clock);
    checkOutput("glitch_idle", {31'd0, rx_busy}, 32'd0);
    checkOutput("glitch_data_kept", {24'd0, data_out}, 32'h0F);

    // Framing error: stop bit forced low
    applyStimulus(8'h3C, 1'b0);
    waitTicks(OS);
    checkOutput("after_err_data", {24'd0, data_out}, 32'h0F);

    // Reset in the middle of data bit 4 of 0xFF, then a clean 0x81
    sendBit(1'b0);
    for (int i = 0; i < 4; i++) sendBit(1'b1);
    #1 rx = 1'b1;
    waitTicks(OS / 2);
    #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    lastGood = '0;
    checkOutput("midreset_busy", {31'd0, rx_busy}, 32'd0);
    checkOutput("midreset_data", {24'd0, data_out}, 32'd0);
    #1 reset = 1'b0;
    waitTicks(2 * OS);
    applyStimulus(8'h81, 1'b1);
    waitTicks(OS);
    checkOutput("final_81", {24'd0, data_out}, 32'h81);

    // Loopback-style sweep of every word at one tick per clock
    tickDiv = 1;
    waitTicks(OS);
    for (int w = 0; w < 256; w++) applyStimulus(w[DW-1:0], 1'b1);

    waitCnt = 0;
    while (sbQueue.size() != 0 && waitCnt < 500) begin
      @(negedge clock);
      waitCnt++;
    end
    checkOutput("scoreboard_drained", sbQueue.size(), 32'd0);
    checkOutput("sweep_last_word", {24'd0, data_out}, 32'hFF);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
